// File: rtl/ltoh_rx_buffer.sv
// Fast-domain receive buffer of the low-to-high crossing: circular memory plus a
// registered valid/ready output stage. Optional drop counter: LTOH_RX_DROP_CNT_EN.
module ltoh_rx_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADD_WIDTH  = 4
) (
    input  logic                  rclk,
    input  logic                  rst_n,
    input  logic                  pe,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADD_WIDTH:0]    fill,
    output logic                  full,
    output logic                  ovf,
    input  logic                  ovf_clr
`ifdef LTOH_RX_DROP_CNT_EN
    ,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int                   DEPTH    = 2 ** ADD_WIDTH;
    localparam logic [ADD_WIDTH:0]   FILL_MAX = (ADD_WIDTH + 1)'(DEPTH);
    localparam logic [ADD_WIDTH:0]   FILL_ONE = (ADD_WIDTH + 1)'(1);
    localparam logic [ADD_WIDTH-1:0] PTR_ONE  = ADD_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADD_WIDTH-1:0]  r_wr_ptr;
    logic [ADD_WIDTH-1:0]  r_rd_ptr;
    logic [ADD_WIDTH:0]    r_fill;
    logic                  r_full;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_ovf;

    logic                  w_wr_en;
    logic                  w_drop;
    logic                  w_load;
    logic [ADD_WIDTH:0]    w_fill_nxt;
    logic                  w_out_valid_nxt;

    // Write acceptance, output load decision and next occupancy / valid state.
    always_comb begin
        w_wr_en         = pe & ~r_full;
        w_drop          = pe & r_full;
        w_load          = (r_fill != {(ADD_WIDTH + 1){1'b0}}) & (~r_out_valid | out_ready);
        w_fill_nxt      = r_fill;
        w_out_valid_nxt = r_out_valid;
        if (w_wr_en & ~w_load) begin
            w_fill_nxt = r_fill + FILL_ONE;
        end else if (~w_wr_en & w_load) begin
            w_fill_nxt = r_fill - FILL_ONE;
        end else begin
            w_fill_nxt = r_fill;
        end
        // With nothing to load, a consumed word leaves the output stage empty.
        if (w_load) begin
            w_out_valid_nxt = 1'b1;
        end else if (out_ready) begin
            w_out_valid_nxt = 1'b0;
        end else begin
            w_out_valid_nxt = r_out_valid;
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge rclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, output stage and sticky overflow flag.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= {ADD_WIDTH{1'b0}};
            r_rd_ptr    <= {ADD_WIDTH{1'b0}};
            r_fill      <= {(ADD_WIDTH + 1){1'b0}};
            r_full      <= 1'b0;
            r_out_data  <= {DATA_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_load) begin
                r_out_data <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            end
            r_fill      <= w_fill_nxt;
            r_full      <= (w_fill_nxt == FILL_MAX);
            r_out_valid <= w_out_valid_nxt;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

`ifdef LTOH_RX_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    // Saturating drop counter; a coincident clear restarts the count at this drop.
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop) begin
            if (ovf_clr) begin
                r_drop_cnt <= 16'd1;
            end else if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end else if (ovf_clr) begin
            r_drop_cnt <= 16'd0;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign fill      = r_fill;
    assign full      = r_full;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ltoh_rx_buffer.sv
// Self-checking bench for ltoh_rx_buffer: vector table, scoreboard queue and
// hand-written corner sequences (overflow, wrap-around, async reset).
module tb_ltoh_rx_buffer;

    localparam int DEPTH = 16;

    logic        rclk = 1'b0;
    logic        rst_n;
    logic        pe;
    logic [31:0] din;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  fill;
    logic        full;
    logic        ovf;
    logic        ovf_clr;
`ifdef LTOH_RX_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    ltoh_rx_buffer #(.DATA_WIDTH(32), .ADD_WIDTH(4)) dut (
        .rclk      (rclk),
        .rst_n     (rst_n),
        .pe        (pe),
        .din       (din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fill      (fill),
        .full      (full),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`ifdef LTOH_RX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic        pe;
        logic [31:0] din;
        logic        rdy;
        logic [31:0] e_data;
        logic        e_valid;
        logic [4:0]  e_fill;
    } vec_t;

    vec_t        tv [5];
    logic [31:0] sb [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_fill;
    bit          m_ov;
    bit          m_ovf;
    int          m_drop;
    int          max_fill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_fill = 0;
        m_ov   = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    // One clock: score the handshake, update the model, advance, compare status.
    task automatic step();
        logic [31:0] e;
        bit acc, drp, ld;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_extra: got %0h expected no word", out_data);
            end else begin
                e = sb.pop_front();
                chk("sb_data", out_data, e);
            end
        end
        drp = pe && (m_fill == DEPTH);
        acc = pe && !drp;
        if (acc) sb.push_back(din);
        ld = (m_fill > 0) && (!m_ov || out_ready);
        m_fill = m_fill + int'(acc) - int'(ld);
        if (ld) m_ov = 1'b1;
        else if (out_ready) m_ov = 1'b0;
        if (drp) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        if (drp) m_drop = ovf_clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : m_drop);
        else if (ovf_clr) m_drop = 0;
        @(posedge rclk);
        #1;
        chk("cyc_fill", 32'(fill), 32'(m_fill));
        chk("cyc_valid", 32'(out_valid), 32'(m_ov));
        chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
        chk("cyc_full", 32'(full), 32'(m_fill == DEPTH));
`ifdef LTOH_RX_DROP_CNT_EN
        chk("cyc_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        if (m_fill > max_fill) max_fill = m_fill;
        pe      = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        pe        = 1'b0;
        din       = 32'd0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_clear();
        repeat (2) @(posedge rclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (sb.size() > 0 || out_valid); i++) step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        tv[0] = '{1'b1, 32'hA, 1'b1, 32'h0, 1'b0, 5'd1};
        tv[1] = '{1'b1, 32'hB, 1'b1, 32'hA, 1'b1, 5'd1};
        tv[2] = '{1'b1, 32'hC, 1'b1, 32'hB, 1'b1, 5'd1};
        tv[3] = '{1'b0, 32'h0, 1'b1, 32'hC, 1'b1, 5'd0};
        tv[4] = '{1'b0, 32'h0, 1'b1, 32'hC, 1'b0, 5'd0};
        max_fill = 0;

        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        // A, B, C in order with one-edge latency
        for (int i = 0; i < 5; i++) begin
            pe        = tv[i].pe;
            din       = tv[i].din;
            out_ready = tv[i].rdy;
            step();
            chk("tv_data", out_data, tv[i].e_data);
            chk("tv_valid", 32'(out_valid), 32'(tv[i].e_valid));
            chk("tv_fill", 32'(fill), 32'(tv[i].e_fill));
        end
        chk("t1_ovf", 32'(ovf), 32'd0);

        // Fill to capacity, then overflow
        out_ready = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            pe  = 1'b1;
            din = 32'(k);
            step();
        end
        chk("t2_head", out_data, 32'd1);
        chk("t2_fill", 32'(fill), 32'd16);
        chk("t2_full", 32'(full), 32'd1);
        pe  = 1'b1;
        din = 32'd18;
        step();
        chk("t2_ovf", 32'(ovf), 32'd1);

        ovf_clr = 1'b1;
        step();
        chk("t5_ovf_clr", 32'(ovf), 32'd0);

        // Full memory: drop and pop in the same cycle
        pe        = 1'b1;
        din       = 32'd19;
        out_ready = 1'b1;
        step();
        chk("t4_ovf", 32'(ovf), 32'd1);
        chk("t4_fill", 32'(fill), 32'd15);

        out_ready = 1'b0;
        pe        = 1'b1;
        din       = 32'd20;
        step();
        pe      = 1'b1;
        din     = 32'd21;
        ovf_clr = 1'b1;
        step();
        chk("t5_set_wins", 32'(ovf), 32'd1);
`ifdef LTOH_RX_DROP_CNT_EN
        chk("t5_cnt_one", 32'(drop_cnt), 32'd1);
`endif
        drain();
        ovf_clr = 1'b1;
        step();
        chk("t5_clr2", 32'(ovf), 32'd0);

        // Wrap-around: 40 words, ready toggling
        max_fill = 0;
        for (int i = 0; i < 80; i++) begin
            pe        = (i % 2 == 0);
            din       = 32'(1000 + i / 2);
            out_ready = (i % 2 == 1);
            step();
        end
        drain();
        chk("t3_max_fill", 32'(max_fill <= DEPTH), 32'd1);
        chk("t3_ovf", 32'(ovf), 32'd0);

        // Asynchronous reset with held words
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pe  = 1'b1;
            din = 32'(200 + k);
            step();
        end
        chk("t6_pre_fill", 32'(fill), 32'd5);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_fill", 32'(fill), 32'd0);
        model_clear();
        #2;
        rst_n     = 1'b1;
        pe        = 1'b1;
        din       = 32'hCAFE_0001;
        out_ready = 1'b1;
        step();
        step();
        chk("t6_x_data", out_data, 32'hCAFE_0001);
        chk("t6_x_valid", 32'(out_valid), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
